// File: rtl/vdp99_host_if.sv
// Command/response and VDP-side bus bundle for vdp99_host.
// master is the command issuer (and VDP data source); slave is vdp99_host.
interface vdp99_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [13:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        vdp_wr_tick;
  logic        vdp_rd_tick;
  logic        vdp_mode;
  logic [7:0]  vdp_din;
  logic [7:0]  vdp_dout;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, vdp_dout,
    input  cmd_ready, rsp_valid, rsp_data, busy,
           vdp_wr_tick, vdp_rd_tick, vdp_mode, vdp_din
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, vdp_dout,
    output cmd_ready, rsp_valid, rsp_data, busy,
           vdp_wr_tick, vdp_rd_tick, vdp_mode, vdp_din
  );
endinterface

// File: rtl/vdp99_host.sv
// Host-side sequencer that turns simple commands into paced vdp99 bus ticks
// (register writes, address setup, data writes, data/status reads).
module vdp99_host #(
  parameter int GAP    = 2,
  parameter int RD_LAT = 1
) (
  input logic         pxclk,
  input logic         reset,
  vdp99_host_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE1, GAP1, ISSUE2, RDWAIT, RSP, TAIL} state_t;

  localparam logic [2:0] OP_WREG  = 3'd0;
  localparam logic [2:0] OP_SETW  = 3'd1;
  localparam logic [2:0] OP_SETR  = 3'd2;
  localparam logic [2:0] OP_WDAT  = 3'd3;
  localparam logic [2:0] OP_RDAT  = 3'd4;
  localparam logic [2:0] OP_RSTAT = 3'd5;

  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);
  localparam logic [3:0] RD_LOAD  = 4'(RD_LAT - 1);

  state_t     state;
  logic [2:0] op;
  logic [5:0] addr_hi;
  logic [2:0] reg_no;
  logic [7:0] gap_cnt;
  logic [3:0] rd_cnt;
  logic       wr_tick;
  logic       rd_tick;
  logic       mode;
  logic [7:0] din;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] second_byte;

  // Second control byte of the two-byte ops, built from the latched command.
  always_comb begin
    second_byte = {2'b00, addr_hi};
    if (op == OP_WREG)      second_byte = {5'b10000, reg_no};
    else if (op == OP_SETW) second_byte = {2'b01, addr_hi};
  end

  // Ticks are launched on the edge entering an ISSUE state so they are high
  // exactly in that state; counters reload as each waiting state is entered.
  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= 3'd0;
      addr_hi   <= 6'd0;
      reg_no    <= 3'd0;
      gap_cnt   <= 8'd0;
      rd_cnt    <= 4'd0;
      wr_tick   <= 1'b0;
      rd_tick   <= 1'b0;
      mode      <= 1'b0;
      din       <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      wr_tick   <= 1'b0;
      rd_tick   <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op      <= bus.cmd_op;
            addr_hi <= bus.cmd_addr[13:8];
            reg_no  <= bus.cmd_addr[2:0];
            state   <= ISSUE1;
            case (bus.cmd_op)
              OP_WREG: begin
                wr_tick <= 1'b1;
                din     <= bus.cmd_data;
                mode    <= 1'b1;
              end
              OP_SETW, OP_SETR: begin
                wr_tick <= 1'b1;
                din     <= bus.cmd_addr[7:0];
                mode    <= 1'b1;
              end
              OP_WDAT: begin
                wr_tick <= 1'b1;
                din     <= bus.cmd_data;
                mode    <= 1'b0;
              end
              OP_RDAT: begin
                rd_tick <= 1'b1;
                mode    <= 1'b0;
              end
              OP_RSTAT: begin
                rd_tick <= 1'b1;
                mode    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ISSUE1: begin
          case (op)
            OP_WREG, OP_SETW, OP_SETR: begin
              state   <= GAP1;
              gap_cnt <= GAP_LOAD;
            end
            OP_WDAT: begin
              state   <= TAIL;
              gap_cnt <= GAP_LOAD;
            end
            OP_RDAT, OP_RSTAT: begin
              state  <= RDWAIT;
              rd_cnt <= RD_LOAD;
            end
            default: state <= IDLE;
          endcase
        end
        GAP1: begin
          if (gap_cnt == 8'd0) begin
            state   <= ISSUE2;
            wr_tick <= 1'b1;
            din     <= second_byte;
            mode    <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        ISSUE2: begin
          state   <= TAIL;
          gap_cnt <= GAP_LOAD;
        end
        RDWAIT: begin
          if (rd_cnt == 4'd0) begin
            rsp_data  <= bus.vdp_dout;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        RSP: begin
          state   <= TAIL;
          gap_cnt <= GAP_LOAD;
        end
        TAIL: begin
          if (gap_cnt == 8'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.vdp_wr_tick = wr_tick;
  assign bus.vdp_rd_tick = rd_tick;
  assign bus.vdp_mode    = mode;
  assign bus.vdp_din     = din;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_data    = rsp_data;

endmodule
